ex_mem_skid: RTL and testbench

//  EX->MEM pipeline stage directly downstream of the ALU. Captures ALU result/flags plus EX control per instruction.

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/ex_mem_skid_if.sv | 40 ++++
 rtl/ex_branch_resolve.sv | 16 +
 rtl/ex_mem_skid.sv | 106 ++++++++++
 tb/tb_ex_mem_skid.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared widths, branch/state enums and the EX->MEM payload struct
package cpu_types_pkg;
  localparam int DW = 32;
  localparam int RW = 5;
  typedef enum logic [1:0] {BR_NONE = 2'd0, BR_EQ = 2'd1, BR_NE = 2'd2} br_t;
  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} skid_state_t;
  typedef struct packed {
    logic [DW-1:0] alu_out;
    logic [DW-1:0] store_data;
    logic [RW-1:0] wsel;
    logic          regwen;
    logic          dren;
    logic          dwen;
  } ex_mem_t;
endpackage

// File: rtl/ex_mem_skid_if.sv
// ex_mem_skid_if: EX-side inputs, MEM-side handshake and branch/exception pulses of the EX->MEM stage
interface ex_mem_skid_if;
  logic                        flush;
  logic                        in_valid;
  logic                        in_ready;
  logic [cpu_types_pkg::DW-1:0] alu_out;
  logic                        alu_zero;
  logic                        alu_ovf;
  logic                        ovf_chk;
  logic [1:0]                  br_type;
  logic [cpu_types_pkg::DW-1:0] br_target;
  logic [cpu_types_pkg::DW-1:0] store_data;
  logic [cpu_types_pkg::RW-1:0] wsel;
  logic                        regwen;
  logic                        dren;
  logic                        dwen;
  logic                        out_valid;
  logic                        out_ready;
  logic [cpu_types_pkg::DW-1:0] out_alu_out;
  logic [cpu_types_pkg::DW-1:0] out_store_data;
  logic [cpu_types_pkg::RW-1:0] out_wsel;
  logic                        out_regwen;
  logic                        out_dren;
  logic                        out_dwen;
  logic                        br_taken;
  logic [cpu_types_pkg::DW-1:0] br_pc;
  logic                        ovf_exc;
  modport slave (
    input  flush, in_valid, alu_out, alu_zero, alu_ovf, ovf_chk, br_type, br_target,
           store_data, wsel, regwen, dren, dwen, out_ready,
    output in_ready, out_valid, out_alu_out, out_store_data, out_wsel, out_regwen,
           out_dren, out_dwen, br_taken, br_pc, ovf_exc
  );
  modport master (
    output flush, in_valid, alu_out, alu_zero, alu_ovf, ovf_chk, br_type, br_target,
           store_data, wsel, regwen, dren, dwen, out_ready,
    input  in_ready, out_valid, out_alu_out, out_store_data, out_wsel, out_regwen,
           out_dren, out_dwen, br_taken, br_pc, ovf_exc
  );
endinterface

// File: rtl/ex_branch_resolve.sv
// ex_branch_resolve: decides BEQ/BNE outcome from the ALU zero flag; unknown types never branch
module ex_branch_resolve
  import cpu_types_pkg::*;
(
  input  logic [1:0]    br_type,
  input  logic          alu_zero,
  input  logic [DW-1:0] br_target,
  output logic          taken,
  output logic [DW-1:0] pc
);
  // taken only for EQ with zero or NE without zero; pc is zero when not taken
  always_comb begin
    taken = (br_type == 2'(BR_EQ)) ? alu_zero : (br_type == 2'(BR_NE)) ? ~alu_zero : 1'b0;
    pc = taken ? br_target : '0;
  end
endmodule

// File: rtl/ex_mem_skid.sv
// ex_mem_skid: EX->MEM stage with 2-entry skid buffer, branch pulse and optional overflow trap (OVF_TRAP_EN)
module ex_mem_skid
  import cpu_types_pkg::*;
(
  input logic          CLK,
  input logic          nRST,
  ex_mem_skid_if.slave bus
);
  skid_state_t   state_q, state_d;
  ex_mem_t       head_q, head_d, skid_q, skid_d, entry;
  logic          in_ready_q, in_ready_d;
  logic          br_taken_q, br_taken_d;
  logic          ovf_exc_q, ovf_exc_d;
  logic [DW-1:0] br_pc_q, br_pc_d, res_pc;
  logic          accept, pop, taken, trap;

  ex_branch_resolve u_br (
    .br_type  (bus.br_type),
    .alu_zero (bus.alu_zero),
    .br_target(bus.br_target),
    .taken    (taken),
    .pc       (res_pc)
  );

`ifndef OVF_TRAP_EN
  logic unused_ovf;
  assign unused_ovf = bus.alu_ovf ^ bus.ovf_chk;
`endif

  // incoming payload; a trapping overflow has its side effects stripped
  always_comb begin
    entry = '{alu_out: bus.alu_out, store_data: bus.store_data, wsel: bus.wsel,
              regwen: bus.regwen, dren: bus.dren, dwen: bus.dwen};
`ifdef OVF_TRAP_EN
    trap = bus.ovf_chk & bus.alu_ovf;
    if (trap) {entry.regwen, entry.dren, entry.dwen} = 3'b000;
`else
    trap = 1'b0;
`endif
  end

  // occupancy transitions; flush overrides everything and empties the buffer
  always_comb begin
    accept = bus.in_valid & in_ready_q & ~bus.flush;
    pop = (state_q != S_EMPTY) & bus.out_ready;
    state_d = state_q;
    head_d = head_q;
    skid_d = skid_q;
    case (state_q)
      S_EMPTY: if (accept) begin
        state_d = S_ONE;
        head_d = entry;
      end
      S_ONE: begin
        if (accept & ~pop) begin
          state_d = S_TWO;
          skid_d = entry;
        end else if (accept) head_d = entry;
        else if (pop) state_d = S_EMPTY;
      end
      S_TWO: if (pop) begin
        state_d = S_ONE;
        head_d = skid_q;
      end
      default: state_d = S_EMPTY;
    endcase
    if (bus.flush) state_d = S_EMPTY;
    in_ready_d = state_d != S_TWO;
    br_taken_d = accept & taken;
    br_pc_d = accept ? res_pc : '0;
    ovf_exc_d = accept & trap;
  end

  // state, payload and pulse registers; reset drops any held entries
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= S_EMPTY;
      head_q <= '0;
      skid_q <= '0;
      in_ready_q <= 1'b1;
      br_taken_q <= 1'b0;
      br_pc_q <= '0;
      ovf_exc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      skid_q <= skid_d;
      in_ready_q <= in_ready_d;
      br_taken_q <= br_taken_d;
      br_pc_q <= br_pc_d;
      ovf_exc_q <= ovf_exc_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = state_q != S_EMPTY;
  assign bus.out_alu_out = head_q.alu_out;
  assign bus.out_store_data = head_q.store_data;
  assign bus.out_wsel = head_q.wsel;
  assign bus.out_regwen = head_q.regwen;
  assign bus.out_dren = head_q.dren;
  assign bus.out_dwen = head_q.dwen;
  assign bus.br_taken = br_taken_q;
  assign bus.br_pc = br_pc_q;
  assign bus.ovf_exc = ovf_exc_q;
endmodule

// File: tb/tb_ex_mem_skid.sv
// tb_ex_mem_skid: queue-model scoreboard plus directed literal checks for ex_mem_skid
module tb_ex_mem_skid;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int total = 0;
  int bad = 0;
  logic run = 1'b0;
`ifdef OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] sd;
    logic [4:0]  ws;
    logic        rw;
    logic        dr;
    logic        dw;
  } ent_t;

  ent_t        mq[$];
  logic        e_br = 1'b0;
  logic [31:0] e_pc = '0;
  logic        e_ovf = 1'b0;

  ex_mem_skid_if bus();
  ex_mem_skid dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  always #5 CLK = ~CLK;

  task automatic chk(input string n, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask

  // model: bounded FIFO of capacity 2, accept when fewer than 2 held
  always @(posedge CLK) begin : mdl
    logic acc, tk, trp;
    ent_t e;
    acc = bus.in_valid && mq.size() < 2 && !bus.flush;
    tk = (bus.br_type == 2'd1 && bus.alu_zero) || (bus.br_type == 2'd2 && !bus.alu_zero);
    trp = TRAP && bus.ovf_chk && bus.alu_ovf;
    if (!nRST || bus.flush) begin
      mq.delete();
      e_br <= 1'b0;
      e_pc <= '0;
      e_ovf <= 1'b0;
    end else begin
      if (mq.size() > 0 && bus.out_ready) void'(mq.pop_front());
      if (acc) begin
        e.a = bus.alu_out;
        e.sd = bus.store_data;
        e.ws = bus.wsel;
        e.rw = trp ? 1'b0 : bus.regwen;
        e.dr = trp ? 1'b0 : bus.dren;
        e.dw = trp ? 1'b0 : bus.dwen;
        mq.push_back(e);
      end
      e_br <= acc && tk;
      e_pc <= (acc && tk) ? bus.br_target : 32'd0;
      e_ovf <= acc && trp;
    end
    run <= 1'b1;
  end

  // every-cycle comparison against the model
  always @(negedge CLK) begin
    if (run) begin
      chk("out_valid", 96'(bus.out_valid), 96'(mq.size() != 0));
      chk("in_ready", 96'(bus.in_ready), 96'(mq.size() < 2));
      chk("br_taken", 96'(bus.br_taken), 96'(e_br));
      chk("br_pc", 96'(bus.br_pc), 96'(e_pc));
      chk("ovf_exc", 96'(bus.ovf_exc), 96'(e_ovf));
      if (mq.size() != 0)
        chk("head", 96'({bus.out_alu_out, bus.out_store_data, bus.out_wsel,
                         bus.out_regwen, bus.out_dren, bus.out_dwen}), 96'(mq[0]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic put(input logic v, input logic [31:0] a, input logic [1:0] bt, input logic z,
                     input logic [31:0] tgt, input logic oc, input logic ov, input logic [2:0] ctl);
    bus.in_valid = v;
    bus.alu_out = a;
    bus.store_data = a ^ 32'hffff_0000;
    bus.wsel = a[4:0];
    bus.br_type = bt;
    bus.alu_zero = z;
    bus.br_target = tgt;
    bus.ovf_chk = oc;
    bus.alu_ovf = ov;
    {bus.regwen, bus.dren, bus.dwen} = ctl;
  endtask

  task automatic idle();
    put(1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 1'b0, 1'b0, 3'b000);
  endtask

  initial begin
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    idle();
    cyc(2);
    chk("rst_in_ready", 96'(bus.in_ready), 96'd1);
    chk("rst_outs", 96'({bus.out_valid, bus.out_alu_out, bus.br_taken, bus.br_pc, bus.ovf_exc}), 96'd0);
    nRST = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      put(1'b1, 32'd100 + 32'(i), 2'd0, 1'b0, 32'd0, 1'b0, 1'b0, 3'b100);
      cyc(1);
      chk("stream_valid", 96'(bus.out_valid), 96'd1);
      chk("stream_data", 96'(bus.out_alu_out), 96'd100 + 96'(i));
      chk("stream_ready", 96'(bus.in_ready), 96'd1);
    end
    idle();
    cyc(1);
    chk("stream_drained", 96'(bus.out_valid), 96'd0);
    bus.out_ready = 1'b0;
    put(1'b1, 32'd200, 2'd0, 1'b0, 32'd0, 1'b0, 1'b0, 3'b010);
    cyc(1);
    put(1'b1, 32'd201, 2'd0, 1'b0, 32'd0, 1'b0, 1'b0, 3'b001);
    cyc(1);
    chk("two_in_ready", 96'(bus.in_ready), 96'd0);
    chk("two_head", 96'(bus.out_alu_out), 96'd200);
    put(1'b1, 32'd202, 2'd1, 1'b1, 32'h44, 1'b0, 1'b0, 3'b100);
    cyc(1);
    chk("full_no_accept_pulse", 96'(bus.br_taken), 96'd0);
    chk("stall_hold", 96'(bus.out_alu_out), 96'd200);
    idle();
    bus.out_ready = 1'b1;
    cyc(1);
    chk("drain_second", 96'(bus.out_alu_out), 96'd201);
    chk("drain_ready", 96'(bus.in_ready), 96'd1);
    cyc(1);
    chk("drain_empty", 96'(bus.out_valid), 96'd0);
    put(1'b1, 32'd0, 2'd1, 1'b1, 32'h40, 1'b0, 1'b0, 3'b000);
    cyc(1);
    chk("beq_taken", 96'(bus.br_taken), 96'd1);
    chk("beq_pc", 96'(bus.br_pc), 96'h40);
    put(1'b1, 32'd0, 2'd2, 1'b1, 32'h50, 1'b0, 1'b0, 3'b000);
    cyc(1);
    chk("bne_zero_none", 96'({bus.br_taken, bus.br_pc}), 96'd0);
    put(1'b1, 32'd7, 2'd2, 1'b0, 32'h80, 1'b0, 1'b0, 3'b000);
    cyc(1);
    chk("bne_pc", 96'({bus.br_taken, bus.br_pc}), 96'({1'b1, 32'h80}));
    put(1'b1, 32'd0, 2'd3, 1'b1, 32'h90, 1'b0, 1'b0, 3'b000);
    cyc(1);
    chk("brtype3_none", 96'({bus.br_taken, bus.br_pc}), 96'd0);
    put(1'b1, 32'd300, 2'd0, 1'b0, 32'd0, 1'b1, 1'b1, 3'b111);
    cyc(1);
    chk("ovf_exc", 96'(bus.ovf_exc), 96'(TRAP));
    chk("ovf_regwen", 96'(bus.out_regwen), 96'(!TRAP));
    put(1'b1, 32'd301, 2'd0, 1'b0, 32'd0, 1'b0, 1'b1, 3'b100);
    cyc(1);
    chk("nochk_exc", 96'(bus.ovf_exc), 96'd0);
    chk("nochk_regwen", 96'(bus.out_regwen), 96'd1);
    bus.out_ready = 1'b0;
    put(1'b1, 32'd400, 2'd0, 1'b0, 32'd0, 1'b0, 1'b0, 3'b100);
    cyc(1);
    put(1'b1, 32'd401, 2'd0, 1'b0, 32'd0, 1'b0, 1'b0, 3'b100);
    cyc(1);
    chk("pre_flush_full", 96'(bus.in_ready), 96'd0);
    bus.flush = 1'b1;
    put(1'b1, 32'd402, 2'd1, 1'b1, 32'h60, 1'b1, 1'b1, 3'b100);
    cyc(1);
    chk("flush_valid", 96'(bus.out_valid), 96'd0);
    chk("flush_ready", 96'(bus.in_ready), 96'd1);
    cyc(1);
    chk("flush_empty_pulses", 96'({bus.out_valid, bus.br_taken, bus.ovf_exc}), 96'd0);
    bus.flush = 1'b0;
    put(1'b1, 32'd500, 2'd0, 1'b0, 32'd0, 1'b0, 1'b0, 3'b100);
    cyc(1);
    put(1'b1, 32'd501, 2'd0, 1'b0, 32'd0, 1'b0, 1'b0, 3'b100);
    cyc(1);
    chk("pre_rst_full", 96'(bus.in_ready), 96'd0);
    idle();
    nRST = 1'b0;
    cyc(1);
    chk("rst2_in_ready", 96'(bus.in_ready), 96'd1);
    chk("rst2_outs", 96'({bus.out_valid, bus.out_alu_out, bus.out_store_data, bus.out_wsel,
                          bus.out_regwen, bus.out_dren, bus.out_dwen}), 96'd0);
    nRST = 1'b1;
    bus.out_ready = 1'b1;
    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
